// File: rtl/md5_block_engine_if.sv
// Block-in / digest-out handshake bundle for the MD5 block engine.
interface md5_block_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [511:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] hash;

    // Upstream padder / downstream consumer side
    modport master (
        output in_valid, in_first, data_in, out_ready,
        input  in_ready, out_valid, hash
    );

    // Engine side
    modport slave (
        input  in_valid, in_first, data_in, out_ready,
        output in_ready, out_valid, hash
    );
endinterface

// File: rtl/md5_block_engine.sv
// MD5 compression engine: one padded 512-bit block per transaction, STEPS_PER_CYCLE
// steps per clock, chaining value kept internally across blocks of a message.
module md5_block_engine #(
    parameter int unsigned STEPS_PER_CYCLE = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 abort,
    md5_block_engine_if.slave    bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_count
);

    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4 &&
        STEPS_PER_CYCLE != 8 && STEPS_PER_CYCLE != 16) begin : g_bad_spc
        $error("md5_block_engine: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Working state is packed {a, b, c, d}
    localparam logic [127:0] Iv = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    localparam logic [5:0] StepInc  = 6'(STEPS_PER_CYCLE);
    localparam logic [5:0] LastStep = 6'(64 - STEPS_PER_CYCLE);

    localparam logic [31:0] KTable [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Indexed by {round, step mod 4}
    localparam logic [4:0] ShiftTable [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // One MD5 step on {a, b, c, d}; message words are little-endian within the block.
    function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [5:0] i,
                                              input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, t;
        logic [3:0]  g;
        logic [4:0]  s;
        logic [63:0] r;
        {a, b, c, d} = st;
        case (i[5:4])
            2'd0: begin f = (b & c) | (~b & d); g = i[3:0];                end
            2'd1: begin f = (d & b) | (~d & c); g = i[3:0] * 4'd5 + 4'd1;  end
            2'd2: begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5;  end
            default: begin f = c ^ (b | ~d);    g = i[3:0] * 4'd7;         end
        endcase
        t = a + f + KTable[i] + bswap32(blk[9'd511 - {g, 5'd0} -: 32]);
        s = ShiftTable[{i[5:4], i[1:0]}];
        r = {t, t} << s;
        return {d, b + r[63:32], b, c};
    endfunction

    state_e             state_q, state_d;
    logic [127:0]       work_q, work_d;
    logic [127:0]       start_q, start_d;
    logic [127:0]       chain_q, chain_d;
    logic [511:0]       blk_q, blk_d;
    logic [5:0]         step_q, step_d;
    logic [127:0]       hash_q, hash_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_next;
    logic [127:0]       sum;

    // STEPS_PER_CYCLE chained steps on the working registers
    always_comb begin
        work_next = work_q;
        for (int unsigned k = 0; k < STEPS_PER_CYCLE; k++) begin
            work_next = md5_step(work_next, step_q + 6'(k), blk_q);
        end
        sum = {start_q[127:96] + work_next[127:96], start_q[95:64] + work_next[95:64],
               start_q[63:32]  + work_next[63:32],  start_q[31:0]  + work_next[31:0]};
    end

    // Next-state logic; abort overrides any handshake in the same cycle
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        start_d = start_q;
        chain_d = chain_q;
        blk_d   = blk_q;
        step_d  = step_q;
        hash_d  = hash_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    blk_d   = bus.data_in;
                    work_d  = bus.in_first ? Iv : chain_q;
                    start_d = bus.in_first ? Iv : chain_q;
                    step_d  = '0;
                    if (bus.in_first) cnt_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d = work_next;
                step_d = step_q + StepInc;
                if (step_q == LastStep) begin
                    chain_d = sum;
                    hash_d  = {bswap32(sum[127:96]), bswap32(sum[95:64]),
                               bswap32(sum[63:32]),  bswap32(sum[31:0])};
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            chain_d = Iv;
            cnt_d   = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            work_q  <= '0;
            start_q <= '0;
            chain_q <= Iv;
            blk_q   <= '0;
            step_q  <= '0;
            hash_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            start_q <= start_d;
            chain_q <= chain_d;
            blk_q   <= blk_d;
            step_q  <= step_d;
            hash_q  <= hash_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.hash      = hash_q;
    assign busy          = (state_q != StIdle);
    assign blk_count     = cnt_q;

endmodule

// File: tb/tb_md5_block_engine.sv
// Directed bench for md5_block_engine: table of known digests plus handshake corner cases.
module tb_md5_block_engine;

    localparam logic [511:0] BlkEmpty = {8'h80, 504'h0};
    localparam logic [511:0] BlkAbc   = {32'h61626380, 416'h0, 8'h18, 56'h0};
    localparam logic [511:0] BlkA64   = {64{8'h61}};
    localparam logic [511:0] BlkPad2  = {8'h80, 440'h0, 16'h0002, 48'h0};
    localparam logic [127:0] HEmpty   = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] HAbc     = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] HA64     = 128'h014842d480b571495a4a0363793f7367;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        busy;
    logic [31:0] blk_count;

    int checks = 0;
    int errors = 0;

    md5_block_engine_if bus();

    md5_block_engine #(.STEPS_PER_CYCLE(1), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .blk_count (blk_count)
    );

    // Extra instances for STEPS_PER_CYCLE = 2, 4, 8, 16 sharing one stimulus
    logic         m_valid = 1'b0;
    logic         m_first = 1'b1;
    logic [511:0] m_data = BlkAbc;
    logic         m_out_ready = 1'b0;
    logic [3:0]   m_ov;
    logic [3:0]   m_busy;
    logic [127:0] m_hash [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_spc
        md5_block_engine_if mbus();
        logic [31:0] mcnt;
        assign mbus.in_valid  = m_valid;
        assign mbus.in_first  = m_first;
        assign mbus.data_in   = m_data;
        assign mbus.out_ready = m_out_ready;
        assign m_ov[gi]       = mbus.out_valid;
        assign m_hash[gi]     = mbus.hash;
        md5_block_engine #(.STEPS_PER_CYCLE(2 << gi), .CNT_W(32)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .abort     (1'b0),
            .bus       (mbus),
            .busy      (m_busy[gi]),
            .blk_count (mcnt)
        );
    end

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer a block, wait for acceptance, then count edges until out_valid
    task automatic send_block(input logic first, input logic [511:0] data,
                              output int lat, output logic [127:0] h);
        int guard = 0;
        @(negedge clk);
        bus.in_first = first;
        bus.data_in  = data;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        h = bus.hash;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic         first;
        logic [511:0] data;
        logic         chk_hash;
        logic [127:0] exp_hash;
        logic [31:0]  exp_cnt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int           lat;
        logic [127:0] h;
        int           bad;
        int           mlat [4];
        logic [127:0] mh [4];

        vecs[0] = '{1'b1, BlkEmpty, 1'b1, HEmpty, 32'd1};
        vecs[1] = '{1'b1, BlkAbc,   1'b1, HAbc,   32'd1};
        vecs[2] = '{1'b1, BlkA64,   1'b0, '0,     32'd1};
        vecs[3] = '{1'b0, BlkPad2,  1'b1, HA64,   32'd2};
        vecs[4] = '{1'b1, BlkAbc,   1'b1, HAbc,   32'd1};

        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_in_ready", 128'(bus.in_ready), 128'd1);
        check("reset_out_valid", 128'(bus.out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_hash", bus.hash, 128'd0);
        check("reset_blk_count", 128'(blk_count), 128'd0);

        // Table of single and chained blocks at one step per cycle
        for (int i = 0; i < 5; i++) begin
            send_block(vecs[i].first, vecs[i].data, lat, h);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd64);
            if (vecs[i].chk_hash) check($sformatf("vec%0d_hash", i), h, vecs[i].exp_hash);
            check($sformatf("vec%0d_blk_count", i), 128'(blk_count), 128'(vecs[i].exp_cnt));
            consume();
            check($sformatf("vec%0d_idle_after", i), 128'({busy, bus.out_valid}), 128'd0);
        end

        // Wider engines: latency 64/SPC, same digest
        @(negedge clk);
        m_valid = 1'b1;
        @(posedge clk);
        #1 m_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mlat[k] = 0;
            mh[k]   = '0;
        end
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (m_ov[k] && mlat[k] == 0) begin
                    mlat[k] = e;
                    mh[k]   = m_hash[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("spc%0d_latency", 2 << k), 128'(mlat[k]), 128'(64 / (2 << k)));
            check($sformatf("spc%0d_hash", 2 << k), mh[k], HAbc);
        end
        @(negedge clk);
        m_out_ready = 1'b1;
        @(posedge clk);
        #1 m_out_ready = 1'b0;
        check("spc_released", 128'({m_ov, m_busy}), 128'd0);

        // Back-pressure: hold out_ready low with a new block pending
        send_block(1'b1, BlkEmpty, lat, h);
        check("bp_first_hash", h, HEmpty);
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.data_in  = BlkAbc;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.hash !== HEmpty || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
        end
        check("bp_hold_stable_cycles_bad", 128'(bad), 128'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("bp_release_not_accepted", 128'({busy, bus.in_ready, bus.out_valid}), 128'b010);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("bp_accept_next_cycle", 128'(busy), 128'd1);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_second_latency", 128'(lat), 128'd64);
        check("bp_second_hash", bus.hash, HAbc);
        consume();

        // Abort at run edge 30, then continue with in_first=0
        @(negedge clk);
        bus.in_first = 1'b1;
        bus.data_in  = BlkEmpty;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_state", 128'({busy, bus.out_valid, bus.in_ready}), 128'b001);
        check("abort_blk_count", 128'(blk_count), 128'd0);
        bad = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        check("abort_no_out_valid", 128'(bad), 128'd0);
        check("abort_hash_kept", bus.hash, HAbc);
        send_block(1'b0, BlkAbc, lat, h);
        check("abort_then_abc_latency", 128'(lat), 128'd64);
        check("abort_then_abc_hash", h, HAbc);
        check("abort_then_blk_count", 128'(blk_count), 128'd1);
        consume();

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        bus.in_first = 1'b1;
        bus.data_in  = BlkAbc;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_outputs", 128'({bus.out_valid, bus.in_ready, busy}), 128'b010);
        check("midreset_hash", bus.hash, 128'd0);
        check("midreset_blk_count", 128'(blk_count), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        send_block(1'b0, BlkEmpty, lat, h);
        check("after_reset_latency", 128'(lat), 128'd64);
        check("after_reset_hash", h, HEmpty);
        check("after_reset_blk_count", 128'(blk_count), 128'd1);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
